// File: rtl/cpu_fetch_sequencer_pkg.sv
// cpu_fetch_sequencer_pkg: state encodings, opcode classes, END opcode and jump condition codes
package cpu_fetch_sequencer_pkg;
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_OPER      = 4'd3;
  localparam logic [3:0] S_APB_WAIT  = 4'd4;
  localparam logic [3:0] S_SCAN_WAIT = 4'd5;
  localparam logic [3:0] S_HALT      = 4'd6;
  localparam logic [3:0] S_FAULT     = 4'd7;
  localparam logic [1:0] CLS_OP    = 2'b00;
  localparam logic [1:0] CLS_CONST = 2'b01;
  localparam logic [1:0] CLS_JMP   = 2'b10;
  localparam logic [1:0] CLS_APB   = 2'b11;
  localparam logic [7:0] OP_END = 8'hFF;
  localparam logic [1:0] JC_ALW  = 2'b00;
  localparam logic [1:0] JC_ACC  = 2'b01;
  localparam logic [1:0] JC_NACC = 2'b10;
  localparam logic [1:0] JC_RSV  = 2'b11;
  function automatic logic jump_taken(input logic [1:0] cond, input logic acc);
    return (cond == JC_ALW) || (cond == JC_ACC && acc) || (cond == JC_NACC && !acc);
  endfunction
endpackage

// File: rtl/cpu_fetch_sequencer_if.sv
// cpu_fetch_sequencer_if: sequencer-to-datapath handshake and strobe bundle
interface cpu_fetch_sequencer_if #(parameter int SCAN_CNT_W = 16);
  logic                  cpu_run;
  logic [7:0]            instr_code;
  logic                  acc_bit;
  logic                  apb_done;
  logic                  scan_trig;
  logic                  halt_req;
  logic                  pm_en;
  logic                  pc_en;
  logic                  pc_ld;
  logic                  ir_en;
  logic                  apb_en;
  logic                  apb_req;
  logic                  exe_en;
  logic                  scan_done;
  logic                  halt_ack;
  logic                  fault;
  logic                  wdt_trip;
  logic [SCAN_CNT_W-1:0] scan_cnt;
  modport master (
    input  cpu_run, instr_code, acc_bit, apb_done, scan_trig, halt_req,
    output pm_en, pc_en, pc_ld, ir_en, apb_en, apb_req, exe_en, scan_done, halt_ack, fault, wdt_trip, scan_cnt
  );
  modport slave (
    output cpu_run, instr_code, acc_bit, apb_done, scan_trig, halt_req,
    input  pm_en, pc_en, pc_ld, ir_en, apb_en, apb_req, exe_en, scan_done, halt_ack, fault, wdt_trip, scan_cnt
  );
endinterface

// File: rtl/cpu_fetch_sequencer_scan_wdt.sv
// cpu_fetch_sequencer_scan_wdt: per-scan cycle watchdog, built only with SCAN_WDT_EN
`ifdef SCAN_WDT_EN
module cpu_fetch_sequencer_scan_wdt #(
  parameter int WDT_W     = 24,
  parameter int WDT_LIMIT = 2**20
)(
  input  logic cpu_clk,
  input  logic cpu_resetn,
  input  logic run,
  input  logic clr,
  output logic trip
);
  localparam logic [WDT_W-1:0] LAST = WDT_W'(WDT_LIMIT - 1);
  logic [WDT_W-1:0] cnt_q, cnt_d;
  assign trip  = run && cnt_q == LAST;
  assign cnt_d = (clr || trip) ? '0 : run ? cnt_q + WDT_W'(1) : cnt_q;
  always_ff @(posedge cpu_clk or negedge cpu_resetn)
    if (!cpu_resetn) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule
`endif

// File: rtl/cpu_fetch_sequencer.sv
// cpu_fetch_sequencer: fetch/decode/execute and scan sequencing for the PLC program memory datapath
// SCAN_WDT_EN adds a per-scan watchdog that trips into FAULT.
module cpu_fetch_sequencer
  import cpu_fetch_sequencer_pkg::*;
#(
  parameter int SCAN_CNT_W = 16
`ifdef SCAN_WDT_EN
  , parameter int WDT_W     = 24
  , parameter int WDT_LIMIT = 2**20
`endif
)(
  input  logic                  cpu_clk,
  input  logic                  cpu_resetn,
  cpu_fetch_sequencer_if.master bus
);
  logic [3:0] state_q, state_d;
  logic [SCAN_CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [3:0] to_fetch;
  logic [1:0] cls;
  logic is_end, trip, go;
  logic pm_en, pc_en, pc_ld, ir_en, apb_en, apb_req, exe_en, scan_done;
  assign cls      = bus.instr_code[7:6];
  assign is_end   = bus.instr_code == OP_END;
  assign to_fetch = bus.halt_req ? S_HALT : S_FETCH;
  assign go       = bus.cpu_run && !trip;
`ifdef SCAN_WDT_EN
  logic wdt_run, wdt_clr;
  assign wdt_run = state_q inside {S_FETCH, S_DECODE, S_OPER, S_APB_WAIT};
  assign wdt_clr = state_q == S_IDLE || (state_q == S_DECODE && is_end);
  cpu_fetch_sequencer_scan_wdt #(.WDT_W(WDT_W), .WDT_LIMIT(WDT_LIMIT)) u_wdt (
    .cpu_clk    (cpu_clk),
    .cpu_resetn (cpu_resetn),
    .run        (wdt_run),
    .clr        (wdt_clr),
    .trip       (trip)
  );
`else
  assign trip = 1'b0;
`endif
  always_comb begin
    state_d   = state_q;
    pm_en     = 1'b0;
    pc_en     = 1'b0;
    pc_ld     = 1'b0;
    ir_en     = 1'b0;
    apb_en    = 1'b0;
    apb_req   = 1'b0;
    exe_en    = 1'b0;
    scan_done = 1'b0;
    case (state_q)
      S_IDLE: state_d = to_fetch;
      S_FETCH: begin
        pm_en   = 1'b1;
        pc_en   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE:
        if (is_end) begin
          pc_en     = 1'b1;
          pc_ld     = 1'b1;
          scan_done = 1'b1;
          state_d   = S_SCAN_WAIT;
        end else if (cls == CLS_OP) begin
          exe_en  = 1'b1;
          state_d = to_fetch;
        end else if (cls == CLS_JMP) begin
          pc_en   = jump_taken(bus.instr_code[1:0], bus.acc_bit);
          pc_ld   = pc_en;
          state_d = bus.instr_code[1:0] == JC_RSV ? S_FAULT : to_fetch;
        end else begin
          ir_en   = 1'b1;
          pm_en   = 1'b1;
          pc_en   = 1'b1;
          state_d = S_OPER;
        end
      // instr_code comes from the IR here, so the class is still the first word's
      S_OPER:
        if (cls == CLS_APB) begin
          apb_en  = 1'b1;
          apb_req = 1'b1;
          state_d = S_APB_WAIT;
        end else begin
          exe_en  = 1'b1;
          state_d = to_fetch;
        end
      S_APB_WAIT: begin
        apb_req = !bus.apb_done;
        state_d = bus.apb_done ? to_fetch : S_APB_WAIT;
      end
      S_SCAN_WAIT: state_d = bus.scan_trig ? to_fetch : S_SCAN_WAIT;
      S_HALT: state_d = bus.halt_req ? S_HALT : S_FETCH;
      default: state_d = state_q;
    endcase
    if (trip) state_d = S_FAULT;
    if (!bus.cpu_run) state_d = S_IDLE;
  end
  assign scan_cnt_d = scan_cnt_q + SCAN_CNT_W'(go && scan_done);
  always_ff @(posedge cpu_clk or negedge cpu_resetn)
    if (!cpu_resetn) begin
      state_q    <= S_IDLE;
      scan_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      scan_cnt_q <= scan_cnt_d;
    end
  assign bus.pm_en     = go && pm_en;
  assign bus.pc_en     = go && pc_en;
  assign bus.pc_ld     = go && pc_ld;
  assign bus.ir_en     = go && ir_en;
  assign bus.apb_en    = go && apb_en;
  assign bus.apb_req   = go && apb_req;
  assign bus.exe_en    = go && exe_en;
  assign bus.scan_done = go && scan_done;
  assign bus.halt_ack  = state_q == S_HALT;
  assign bus.fault     = state_q == S_FAULT;
  assign bus.wdt_trip  = trip;
  assign bus.scan_cnt  = scan_cnt_q;
endmodule

// File: tb/tb_cpu_fetch_sequencer.sv
// tb_cpu_fetch_sequencer: directed scenarios against a small PC/IR/program-memory model
// scan_cnt is narrowed to 8 bits so the wrap is reachable in a short run.
module tb_cpu_fetch_sequencer;
  localparam int CW = 8;
  localparam logic [10:0] Z   = 11'h000;
  localparam logic [10:0] PM  = 11'h400;
  localparam logic [10:0] PCE = 11'h200;
  localparam logic [10:0] PLD = 11'h100;
  localparam logic [10:0] IRE = 11'h080;
  localparam logic [10:0] APE = 11'h040;
  localparam logic [10:0] ARQ = 11'h020;
  localparam logic [10:0] EXE = 11'h010;
  localparam logic [10:0] SDN = 11'h008;
  localparam logic [10:0] HAK = 11'h004;
  localparam logic [10:0] FLT = 11'h002;
  localparam logic [10:0] WDT = 11'h001;
  logic cpu_clk, cpu_resetn;
  int errors = 0, checks = 0;
  logic [31:0] pm [256];
  logic [31:0] pm_reg;
  logic [7:0]  pc, ir;
  logic [1:0]  ir_hold;
  cpu_fetch_sequencer_if #(.SCAN_CNT_W(CW)) bus();
  cpu_fetch_sequencer #(
    .SCAN_CNT_W(CW)
`ifdef SCAN_WDT_EN
    , .WDT_LIMIT(16)
`endif
  ) dut (
    .cpu_clk    (cpu_clk),
    .cpu_resetn (cpu_resetn),
    .bus        (bus)
  );
  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;
  always @(posedge cpu_clk or negedge cpu_resetn)
    if (!cpu_resetn) begin
      pc <= 8'd0; pm_reg <= 32'd0; ir <= 8'd0; ir_hold <= 2'd0;
    end else begin
      if (bus.pm_en) pm_reg <= pm[pc];
      if (bus.pc_en) pc <= bus.pc_ld ? pm_reg[7:0] : pc + 8'd1;
      if (bus.ir_en) begin ir <= pm_reg[31:24]; ir_hold <= 2'd3; end
      else if (ir_hold != 2'd0) ir_hold <= ir_hold - 2'd1;
    end
  assign bus.instr_code = ir_hold != 2'd0 ? ir : pm_reg[31:24];
  function automatic logic [10:0] outs();
    return {bus.pm_en, bus.pc_en, bus.pc_ld, bus.ir_en, bus.apb_en, bus.apb_req,
            bus.exe_en, bus.scan_done, bus.halt_ack, bus.fault, bus.wdt_trip};
  endfunction
  task automatic cyc();
    @(posedge cpu_clk); #2;
  endtask
  task automatic clear_pm();
    foreach (pm[i]) pm[i] = 32'd0;
  endtask
  task automatic restart();
    bus.cpu_run = 0; bus.acc_bit = 0; bus.apb_done = 0; bus.scan_trig = 0; bus.halt_req = 0;
    cpu_resetn = 0;
    cyc();
    cpu_resetn = 1;
  endtask
  task automatic test_reset();
    clear_pm(); pm[0] = 32'hFF000000;
    restart(); bus.cpu_run = 1;
    repeat (3) cyc();
    #1; checks++;
    if (bus.scan_cnt !== 8'd1) begin errors++; $display("FAIL reset_pre_cnt: got %h want 01", bus.scan_cnt); end
    cyc(); #1;
    cpu_resetn = 0; #1;
    checks++;
    if (outs() !== Z) begin errors++; $display("FAIL reset_outs: got %h want %h", outs(), Z); end
    checks++;
    if (bus.scan_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %h want 00", bus.scan_cnt); end
    cyc(); cyc(); #1; checks++;
    if (outs() !== Z) begin errors++; $display("FAIL reset_hold: got %h want %h", outs(), Z); end
    cpu_resetn = 1;
  endtask
  task automatic test_single_word();
    logic [10:0] exp [4];
    exp = '{Z, PM|PCE, EXE, PM|PCE};
    clear_pm(); pm[0] = 32'h01000005;
    restart(); bus.cpu_run = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      #1; checks++;
      if (outs() !== exp[i]) begin errors++; $display("FAIL single_c%0d: got %h want %h", i, outs(), exp[i]); end
      if (i == 2) begin
        checks++;
        if (bus.instr_code !== 8'h01) begin errors++; $display("FAIL single_op: got %h want 01", bus.instr_code); end
      end
    end
    checks++;
    if (pc !== 8'd1) begin errors++; $display("FAIL single_pc: got %h want 01", pc); end
  endtask
  task automatic test_const();
    logic [10:0] exp [5];
    exp = '{Z, PM|PCE, IRE|PM|PCE, EXE, PM|PCE};
    clear_pm(); pm[0] = 32'h40000000; pm[1] = 32'hDEADBEEF;
    restart(); bus.cpu_run = 1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cyc();
      #1; checks++;
      if (outs() !== exp[i]) begin errors++; $display("FAIL const_c%0d: got %h want %h", i, outs(), exp[i]); end
      if (i == 3) begin
        checks++;
        if (bus.instr_code !== 8'h40) begin errors++; $display("FAIL const_ir: got %h want 40", bus.instr_code); end
      end
    end
    checks++;
    if (pc !== 8'd2) begin errors++; $display("FAIL const_pc: got %h want 02", pc); end
  endtask
  task automatic test_jump();
    logic [10:0] exp [10];
    exp = '{Z, PM|PCE, Z, PM|PCE, PCE|PLD, PM|PCE, Z, FLT, FLT, Z};
    clear_pm(); pm[0] = 32'h81000010; pm[1] = 32'h81000010; pm[16] = 32'h83000000;
    restart(); bus.cpu_run = 1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) cyc();
      if (i == 3) bus.acc_bit = 1;
      if (i == 8) bus.cpu_run = 0;
      #1; checks++;
      if (outs() !== exp[i]) begin errors++; $display("FAIL jump_c%0d: got %h want %h", i, outs(), exp[i]); end
      if (i == 3) begin
        checks++;
        if (pc !== 8'h01) begin errors++; $display("FAIL jump_nt_pc: got %h want 01", pc); end
      end
      if (i == 5) begin
        checks++;
        if (pc !== 8'h10) begin errors++; $display("FAIL jump_t_pc: got %h want 10", pc); end
      end
    end
  endtask
  task automatic test_apb_halt();
    logic [10:0] exp [12];
    exp = '{Z, PM|PCE, IRE|PM|PCE, APE|ARQ, ARQ, ARQ, ARQ, ARQ, Z, HAK, HAK, PM|PCE};
    clear_pm(); pm[0] = 32'hC0000000; pm[1] = 32'h00001234;
    restart(); bus.cpu_run = 1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) cyc();
      if (i == 5) bus.halt_req = 1;
      bus.apb_done = i == 8;
      if (i == 10) bus.halt_req = 0;
      #1; checks++;
      if (outs() !== exp[i]) begin errors++; $display("FAIL apb_c%0d: got %h want %h", i, outs(), exp[i]); end
      if (i == 3) begin
        checks++;
        if (bus.instr_code !== 8'hC0) begin errors++; $display("FAIL apb_ir: got %h want C0", bus.instr_code); end
      end
    end
    checks++;
    if (pc !== 8'd2) begin errors++; $display("FAIL apb_pc: got %h want 02", pc); end
  endtask
  task automatic test_scan_wrap();
    logic [10:0] exp [14];
    exp = '{Z, Z, PM|PCE, EXE, PM|PCE, EXE, PM|PCE, EXE, PM|PCE, PCE|PLD|SDN, Z, Z, Z, PM|PCE};
    clear_pm(); pm[0] = 32'hFF000000;
    restart(); bus.cpu_run = 1; bus.scan_trig = 1;
    repeat (765) cyc();
    bus.scan_trig = 0; #1;
    checks++;
    if (bus.scan_cnt !== 8'hFF) begin errors++; $display("FAIL scan_pre_cnt: got %h want FF", bus.scan_cnt); end
    checks++;
    if (outs() !== Z) begin errors++; $display("FAIL scan_wait: got %h want %h", outs(), Z); end
    pm[0] = 32'd0; pm[3] = 32'hFF000000;
    for (int i = 0; i < 14; i++) begin
      cyc();
      bus.scan_trig = i == 1 || i == 7 || i == 12;
      #1; checks++;
      if (outs() !== exp[i]) begin errors++; $display("FAIL scan_c%0d: got %h want %h", i, outs(), exp[i]); end
      if (i == 10) begin
        checks++;
        if (bus.scan_cnt !== 8'h00) begin errors++; $display("FAIL scan_wrap: got %h want 00", bus.scan_cnt); end
        checks++;
        if (pc !== 8'd0) begin errors++; $display("FAIL scan_pc: got %h want 00", pc); end
      end
    end
  endtask
`ifdef SCAN_WDT_EN
  task automatic test_wdt();
    logic [10:0] e;
    clear_pm(); pm[0] = 32'h80000000;
    restart(); bus.cpu_run = 1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) cyc();
      if (i == 18) bus.cpu_run = 0;
      e = i == 0 ? Z : i == 16 ? WDT : i == 17 || i == 18 ? FLT : i == 19 ? Z : i[0] ? PM|PCE : PCE|PLD;
      #1; checks++;
      if (outs() !== e) begin errors++; $display("FAIL wdt_c%0d: got %h want %h", i, outs(), e); end
    end
  endtask
`endif
  initial begin
    cpu_resetn = 1;
    test_single_word();
    test_const();
    test_jump();
    test_apb_halt();
    test_scan_wrap();
`ifdef SCAN_WDT_EN
    test_wdt();
`endif
    test_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
